// File: rtl/alu_lease_client_pkg.sv
// Shared types for the pooled-ALU lease client: operand/answer bundles
// and the lease FSM state encoding.
package alu_lease_client_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_e;

    typedef struct packed {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
    } alu_ans_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        RESULT  = 2'd2
    } lease_state_e;

endpackage

// File: rtl/alu_lease_client.sv
// Requester-side lease agent: takes one ALU op, leases an ALU from the pool,
// captures the answer and hands it back over valid/ready.
module alu_lease_client
    import alu_lease_client_pkg::*;
#(
    parameter int ID_WIDTH = 16,
    parameter int MAX_WAIT = 64,
    parameter int STAT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  alu_req_t            op_req,
    input  logic [ID_WIDTH-1:0] op_id,
    input  logic                flush,
    // pool request packed as {req, id}
    output logic [ID_WIDTH:0]   rpl_out,
    input  logic                grant_in,
    output alu_req_t            alu_req_out,
    input  alu_ans_t            alu_ans_in,
    output logic                res_valid,
    input  logic                res_ready,
    output alu_ans_t            res_ans,
    output logic [ID_WIDTH-1:0] res_id,
    output logic                res_timeout,
    output logic [STAT_W-1:0]   wait_cycles
);

    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int LAST  = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);
    localparam bit TO_EN = (MAX_WAIT != 0);

    lease_state_e        state_q, state_d;
    alu_req_t            op_q, op_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    alu_ans_t            ans_q, ans_d;
    logic                to_q, to_d;
    logic [STAT_W-1:0]   wait_q, wait_d;
    logic [ID_WIDTH:0]   rpl_q, rpl_d;
    alu_req_t            alu_q, alu_d;
    logic                valid_q, valid_d;

    assign op_ready = (state_q == IDLE) && !flush && !rst;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        ans_d   = ans_q;
        to_d    = to_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (op_valid && op_ready) begin
                    op_d    = op_req;
                    id_d    = op_id;
                    cnt_d   = '0;
                    state_d = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (!grant_in && wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
                // flush beats grant, grant beats timeout
                if (flush) begin
                    state_d = IDLE;
                end else if (grant_in) begin
                    ans_d   = alu_ans_in;
                    to_d    = 1'b0;
                    state_d = RESULT;
                end else if (TO_EN && cnt_q == CNT_LAST) begin
                    ans_d   = '0;
                    to_d    = 1'b1;
                    state_d = RESULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESULT: begin
                if (flush || res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rpl_d   = (state_d == ACQUIRE) ? {1'b1, id_d} : '0;
        alu_d   = (state_d == ACQUIRE) ? op_d : '0;
        valid_d = (state_d == RESULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            ans_q   <= '0;
            to_q    <= 1'b0;
            wait_q  <= '0;
            rpl_q   <= '0;
            alu_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            ans_q   <= ans_d;
            to_q    <= to_d;
            wait_q  <= wait_d;
            rpl_q   <= rpl_d;
            alu_q   <= alu_d;
            valid_q <= valid_d;
        end
    end

    assign rpl_out     = rpl_q;
    assign alu_req_out = alu_q;
    assign res_valid   = valid_q;
    assign res_ans     = ans_q;
    assign res_id      = id_q;
    assign res_timeout = to_q;
    assign wait_cycles = wait_q;

endmodule
